branch_resolve_queue: RTL and testbench

Tracks in-flight branch predictions between fetch and ID, checks each one against the resolved outcome from ID, and produces the BTB write/train request and a fetch redirect on misprediction. Sits between the fetch-stage BTB lookup and the ID-stage branch unit. Its update outputs drive the BTB correction port. Its redirect outputs drive PC generation.

---
 rtl/bpu_pkg.sv | 47 ++++
 rtl/bpq_fifo.sv | 70 +++++++
 rtl/branch_resolve_queue.sv | 108 ++++++++++
 tb/tb_branch_resolve_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared branch-prediction definitions.
// Holds the BTB field widths, the packed layout of branch_info, the branch
// type encodings, and the entry stored in the branch resolve queue.
package bpu_pkg;

    localparam int TAG_W = 22;
    localparam int IDX_W = 8;
    localparam int TAR_W = 32;
    localparam int TYP_W = 2;

    // branch_info = {type, dir, tar}
    localparam int BI_TAR_LO = 0;
    localparam int BI_TAR_HI = 31;
    localparam int BI_DIR    = 32;
    localparam int BI_TYP_LO = 33;
    localparam int BI_TYP_HI = 34;
    localparam int BI_W      = 35;

    typedef enum logic [TYP_W-1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic             hit;
        logic [TYP_W-1:0] btype;
        logic [TAR_W-1:0] tar;
        logic             dir;
    } bpq_entry_t;

    function automatic logic [BI_W-1:0] pack_branch_info(
        input logic [TYP_W-1:0] typ,
        input logic             dir,
        input logic [TAR_W-1:0] tar
    );
        logic [BI_W-1:0] info;
        info                        = '0;
        info[BI_TYP_HI:BI_TYP_LO]   = typ;
        info[BI_DIR]                = dir;
        info[BI_TAR_HI:BI_TAR_LO]   = tar;
        return info;
    endfunction

endpackage

// File: rtl/bpq_fifo.sv
// Generic circular buffer with a flush that discards everything behind the
// entry being popped.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   push, wr_data      write request and data (dropped when full unless a pop
//                      frees a slot in the same cycle)
//   pop                remove head (ignored when empty)
//   flush              empty the buffer on this edge; wins over push
//   rd_data            head entry, combinational
//   full, empty        occupancy flags derived from the registered count
module bpq_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    assign do_pop     = pop & ~empty;
    // A pop in the same cycle frees the slot being written, so full does not block.
    assign do_push    = push & (~full | do_pop) & ~flush;
    assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // On flush the write pointer collapses onto the post-pop read pointer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= rd_ptr_nxt;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight branch predictions from fetch, checks the oldest against
// the outcome resolved in ID, and emits a one-cycle BTB update plus a fetch
// redirect on misprediction. A misprediction flushes all younger entries.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   push_*                      prediction from the fetch-stage BTB lookup
//   full, empty                 queue occupancy
//   res_*                       resolved outcome of the oldest branch
//   upd_valid, pred_flag,
//   corr_tag, corr_index,
//   branch_info                 registered BTB correction request
//   redirect_valid, redirect_pc registered fetch redirect
//   mispred_cnt                 mispredictions since reset (wrapping)
module branch_resolve_queue
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic             push_hit,
    input  logic [TYP_W-1:0] push_type,
    input  logic [TAR_W-1:0] push_tar,
    input  logic             push_dir,
    output logic             full,
    output logic             empty,
    input  logic             res_valid,
    input  logic             res_dir,
    input  logic [TYP_W-1:0] res_type,
    input  logic [TAR_W-1:0] res_tar,
    output logic             upd_valid,
    output logic             pred_flag,
    output logic [TAG_W-1:0] corr_tag,
    output logic [IDX_W-1:0] corr_index,
    output logic [BI_W-1:0]  branch_info,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      mispred_cnt
);

    localparam int ENTRY_W = $bits(bpq_entry_t);

    bpq_entry_t       push_entry;
    bpq_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;
    logic             resolve_acc;
    logic             pt;
    logic             mis;
    logic             flush;

    assign push_entry = '{pc: push_pc, hit: push_hit, btype: push_type,
                          tar: push_tar, dir: push_dir};
    assign head       = bpq_entry_t'(head_bits);

    bpq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push_valid),
        .wr_data (push_entry),
        .pop     (res_valid),
        .flush   (flush),
        .rd_data (head_bits),
        .full    (full),
        .empty   (empty)
    );

    // A BTB miss always predicts not-taken, so only a hit can carry a taken
    // prediction or a type that disagrees with the resolved type.
    assign resolve_acc = res_valid & ~empty;
    assign pt          = head.hit & head.dir;
    assign mis         = (pt != res_dir)
                       | (pt & res_dir & (head.tar != res_tar))
                       | (head.hit & (head.btype != res_type));
    assign flush       = resolve_acc & mis;

    // Not-taken redirect skips the delay slot, hence pc + 8.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            upd_valid      <= 1'b0;
            pred_flag      <= 1'b0;
            corr_tag       <= '0;
            corr_index     <= '0;
            branch_info    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mispred_cnt    <= '0;
        end else begin
            upd_valid      <= resolve_acc;
            redirect_valid <= flush;
            if (resolve_acc) begin
                pred_flag   <= ~mis;
                corr_tag    <= head.pc[31:IDX_W+2];
                corr_index  <= head.pc[IDX_W+1:2];
                branch_info <= pack_branch_info(res_type, res_dir, res_tar);
            end
            if (flush) begin
                redirect_pc <= res_dir ? res_tar : head.pc + 32'd8;
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a reference queue model predicts
// each resolve, pushes the expected update onto a scoreboard, and the
// scoreboard is drained as update pulses appear.
module tb_branch_resolve_queue;
    import bpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = '0;
    logic        push_hit = 1'b0;
    logic [1:0]  push_type = '0;
    logic [31:0] push_tar = '0;
    logic        push_dir = 1'b0;
    logic        full;
    logic        empty;
    logic        res_valid = 1'b0;
    logic        res_dir = 1'b0;
    logic [1:0]  res_type = '0;
    logic [31:0] res_tar = '0;
    logic        upd_valid;
    logic        pred_flag;
    logic [21:0] corr_tag;
    logic [7:0]  corr_index;
    logic [34:0] branch_info;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [1:0]  typ;
        logic [31:0] tar;
        logic        dir;
    } model_entry_t;

    typedef struct {
        logic        pf;
        logic [21:0] tag;
        logic [7:0]  idx;
        logic [34:0] info;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    model_entry_t model_q[$];
    exp_t         sb[$];
    logic [31:0]  exp_cnt = '0;
    int           checks = 0;
    int           failures = 0;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_hit       (push_hit),
        .push_type      (push_type),
        .push_tar       (push_tar),
        .push_dir       (push_dir),
        .full           (full),
        .empty          (empty),
        .res_valid      (res_valid),
        .res_dir        (res_dir),
        .res_type       (res_type),
        .res_tar        (res_tar),
        .upd_valid      (upd_valid),
        .pred_flag      (pred_flag),
        .corr_tag       (corr_tag),
        .corr_index     (corr_index),
        .branch_info    (branch_info),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compares the registered outputs against the scoreboard after an edge.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("upd_valid", upd_valid, 1'b1);
            chk("pred_flag", pred_flag, e.pf);
            chk("corr_tag", corr_tag, e.tag);
            chk("corr_index", corr_index, e.idx);
            chk("branch_info", branch_info, e.info);
            chk("redirect_valid", redirect_valid, e.rv);
            if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
        end else begin
            chk("upd_idle", upd_valid, 1'b0);
            chk("redirect_idle", redirect_valid, 1'b0);
        end
        chk("mispred_cnt", mispred_cnt, exp_cnt);
        chk("empty", empty, model_q.size() == 0);
        chk("full", full, model_q.size() == DEPTH);
    endtask

    // Drives one cycle of inputs, advances the model, then checks outputs.
    task automatic applyStimulus(
        input logic pv, input logic [31:0] ppc, input logic phit,
        input logic [1:0] ptyp, input logic [31:0] ptar, input logic pdir,
        input logic rv, input logic rdir, input logic [1:0] rtyp,
        input logic [31:0] rtar
    );
        model_entry_t h, n;
        exp_t         e;
        logic         pop_acc, pt, mis, push_acc;
        @(negedge clk);
        push_valid = pv; push_pc = ppc; push_hit = phit;
        push_type = ptyp; push_tar = ptar; push_dir = pdir;
        res_valid = rv; res_dir = rdir; res_type = rtyp; res_tar = rtar;
        pop_acc = rv && (model_q.size() > 0);
        mis = 1'b0;
        if (pop_acc) begin
            h   = model_q[0];
            pt  = h.hit && h.dir;
            mis = (pt != rdir) || (pt && rdir && h.tar != rtar) || (h.hit && h.typ != rtyp);
            e.pf   = !mis;
            e.tag  = h.pc >> 10;
            e.idx  = 8'((h.pc >> 2) & 32'hFF);
            e.info = {rtyp, rdir, rtar};
            e.rv   = mis;
            e.rpc  = rdir ? rtar : h.pc + 32'd8;
            sb.push_back(e);
            if (mis) exp_cnt = exp_cnt + 32'd1;
        end
        push_acc = pv && (model_q.size() < DEPTH || pop_acc) && !mis;
        if (pop_acc) void'(model_q.pop_front());
        if (mis) model_q.delete();
        if (push_acc) begin
            n = '{pc: ppc, hit: phit, typ: ptyp, tar: ptar, dir: pdir};
            model_q.push_back(n);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doPush(input logic [31:0] pc, input logic hit, input logic [1:0] typ,
                          input logic [31:0] tar, input logic dir);
        applyStimulus(1'b1, pc, hit, typ, tar, dir, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic doResolve(input logic dir, input logic [1:0] typ, input logic [31:0] tar);
        applyStimulus(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, dir, typ, tar);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    // Reset held for one edge while a resolve and a push are presented.
    task automatic applyReset();
        @(negedge clk);
        resetn = 1'b0;
        push_valid = 1'b1; push_pc = 32'h5000; push_hit = 1'b1;
        res_valid = 1'b1; res_dir = 1'b1; res_tar = 32'h7777;
        model_q.delete();
        sb.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        resetn = 1'b1;
        push_valid = 1'b0; res_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        resetn = 1'b1;

        // Correct taken prediction.
        doPush(32'h1000, 1'b1, BR_COND, 32'h2000, 1'b1);
        doResolve(1'b1, BR_COND, 32'h2000);
        doIdle();

        // BTB miss but branch taken.
        doPush(32'h1004, 1'b0, BR_COND, 32'h0, 1'b0);
        doResolve(1'b1, BR_COND, 32'h3000);
        doIdle();

        // Predicted taken, actually not taken: redirect to pc + 8.
        doPush(32'h1010, 1'b1, BR_COND, 32'h1100, 1'b1);
        doResolve(1'b0, BR_COND, 32'h1100);
        doIdle();

        // Resolve while empty is ignored.
        doResolve(1'b1, BR_JUMP, 32'h4444);

        // Fill, drop a fifth push, push+resolve while full, then drain.
        doPush(32'h2000, 1'b1, BR_COND, 32'h0, 1'b0);
        doPush(32'h2004, 1'b1, BR_COND, 32'h0, 1'b0);
        doPush(32'h2008, 1'b0, BR_CALL, 32'h0, 1'b0);
        doPush(32'h200C, 1'b1, BR_JUMP, 32'h9000, 1'b1);
        doPush(32'h2010, 1'b1, BR_COND, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h2014, 1'b1, BR_RET, 32'hA000, 1'b1,
                      1'b1, 1'b0, BR_COND, 32'h0);
        doResolve(1'b0, BR_COND, 32'h0);
        doResolve(1'b0, BR_JUMP, 32'h0);
        doResolve(1'b1, BR_JUMP, 32'h9000);
        doResolve(1'b1, BR_RET, 32'hA000);
        doIdle();

        // Three entries; head mispredicts on target while a push arrives.
        doPush(32'h3000, 1'b1, BR_JUMP, 32'h3100, 1'b1);
        doPush(32'h3004, 1'b1, BR_COND, 32'h0, 1'b0);
        doPush(32'h3008, 1'b0, BR_COND, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h300C, 1'b1, BR_COND, 32'h0, 1'b0,
                      1'b1, 1'b1, BR_JUMP, 32'h3200);
        doIdle();
        doPush(32'h3400, 1'b1, BR_CALL, 32'h3800, 1'b1);
        doResolve(1'b1, BR_RET, 32'h3800);
        doIdle();

        // Type differs on a miss entry: no mispredict.
        doPush(32'h0FFFFC00, 1'b0, BR_CALL, 32'h0, 1'b0);
        doResolve(1'b0, BR_COND, 32'h0);

        // Reset mid-stream with a resolve pending.
        doPush(32'h6000, 1'b1, BR_COND, 32'h6100, 1'b1);
        doPush(32'h6004, 1'b1, BR_COND, 32'h0, 1'b0);
        applyReset();
        doIdle();
        doPush(32'h7000, 1'b1, BR_COND, 32'h7100, 1'b1);
        doResolve(1'b1, BR_COND, 32'h7100);
        doIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
